// File: rtl/frame_buffer_write_arbiter.sv
// Arbitrates the frame-buffer write port between rasterizer writes and a full-frame clear sweep.
// Define ARB_ROUND_ROBIN_EN for round-robin sharing during a clear; the default gives the sweep strict priority.
module frame_buffer_write_arbiter #(
  parameter int HORIZ_RESOLUTION   = 80,
  parameter int VERT_RESOLUTION    = 60,
  parameter int FRAME_BUFFER_WIDTH = 12,
  localparam int HW = $clog2(HORIZ_RESOLUTION),
  localparam int VW = $clog2(VERT_RESOLUTION)
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic                          i_clear_go,
  input  logic [FRAME_BUFFER_WIDTH-1:0] i_clear_color,
  input  logic                          i_rast_valid,
  output logic                          o_rast_ready,
  input  logic [VW-1:0]                 i_rast_vert_addr,
  input  logic [HW-1:0]                 i_rast_horiz_addr,
  input  logic [FRAME_BUFFER_WIDTH-1:0] i_rast_data,
  output logic                          o_fb_write_en,
  output logic [VW-1:0]                 o_fb_vert_addr,
  output logic [HW-1:0]                 o_fb_horiz_addr,
  output logic [FRAME_BUFFER_WIDTH-1:0] o_fb_data,
  output logic                          o_clear_busy,
  output logic                          o_clear_done
);

  // Handshake: a rasterizer write transfers in any cycle where i_rast_valid and
  // o_rast_ready are both high; o_rast_ready never looks at i_rast_valid, and the
  // write appears on the registered port in the following cycle.

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [HW-1:0] H_LAST = HW'(HORIZ_RESOLUTION - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VERT_RESOLUTION - 1);

  state_t                        state;
  logic [HW-1:0]                 h_cnt;
  logic [VW-1:0]                 v_cnt;
  logic [FRAME_BUFFER_WIDTH-1:0] clear_color;
  logic                          rast_slot_ok;
  logic                          rast_xfer;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {T_CLEAR, T_RAST} turn_t;
  turn_t turn;
  assign rast_slot_ok = (state == S_CLEAR) && (turn == T_RAST);
`else
  assign rast_slot_ok = 1'b0;
`endif

  // Held low during reset so every output reads 0 while i_arst is asserted.
  assign o_rast_ready = ~i_arst & ((state == S_IDLE) | rast_slot_ok);
  assign rast_xfer    = i_rast_valid & o_rast_ready;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state           <= S_IDLE;
      h_cnt           <= '0;
      v_cnt           <= '0;
      clear_color     <= '0;
      o_fb_write_en   <= 1'b0;
      o_fb_vert_addr  <= '0;
      o_fb_horiz_addr <= '0;
      o_fb_data       <= '0;
      o_clear_busy    <= 1'b0;
      o_clear_done    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      turn            <= T_CLEAR;
`endif
    end else begin
      o_fb_write_en <= 1'b0;
      o_clear_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rast_xfer) begin
            o_fb_write_en   <= 1'b1;
            o_fb_vert_addr  <= i_rast_vert_addr;
            o_fb_horiz_addr <= i_rast_horiz_addr;
            o_fb_data       <= i_rast_data;
          end
          if (i_clear_go) begin
            state        <= S_CLEAR;
            clear_color  <= i_clear_color;
            h_cnt        <= '0;
            v_cnt        <= '0;
            o_clear_busy <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            turn         <= T_CLEAR;
`endif
          end
        end
        S_CLEAR: begin
          if (rast_xfer) begin
            o_fb_write_en   <= 1'b1;
            o_fb_vert_addr  <= i_rast_vert_addr;
            o_fb_horiz_addr <= i_rast_horiz_addr;
            o_fb_data       <= i_rast_data;
`ifdef ARB_ROUND_ROBIN_EN
            turn            <= T_CLEAR;
`endif
          end else begin
            o_fb_write_en   <= 1'b1;
            o_fb_vert_addr  <= v_cnt;
            o_fb_horiz_addr <= h_cnt;
            o_fb_data       <= clear_color;
`ifdef ARB_ROUND_ROBIN_EN
            turn            <= T_RAST;
`endif
            if (h_cnt == H_LAST) begin
              h_cnt <= '0;
              if (v_cnt == V_LAST) begin
                // Last pixel: done pulses alongside this write as busy drops.
                v_cnt        <= '0;
                state        <= S_IDLE;
                o_clear_busy <= 1'b0;
                o_clear_done <= 1'b1;
              end else begin
                v_cnt <= v_cnt + 1'b1;
              end
            end else begin
              h_cnt <= h_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
// Self-checking bench for frame_buffer_write_arbiter with H=4, V=3, FBW=12.
module tb_frame_buffer_write_arbiter;

  localparam int H = 4;
  localparam int V = 3;
  localparam int FBW = 12;
  localparam int HW = 2;
  localparam int VW = 2;
  localparam int W = VW + HW + FBW;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           i_clk = 1'b0;
  logic           i_arst;
  logic           i_clear_go;
  logic [FBW-1:0] i_clear_color;
  logic           i_rast_valid;
  logic           o_rast_ready;
  logic [VW-1:0]  i_rast_vert_addr;
  logic [HW-1:0]  i_rast_horiz_addr;
  logic [FBW-1:0] i_rast_data;
  logic           o_fb_write_en;
  logic [VW-1:0]  o_fb_vert_addr;
  logic [HW-1:0]  o_fb_horiz_addr;
  logic [FBW-1:0] o_fb_data;
  logic           o_clear_busy;
  logic           o_clear_done;

  frame_buffer_write_arbiter #(
    .HORIZ_RESOLUTION(H), .VERT_RESOLUTION(V), .FRAME_BUFFER_WIDTH(FBW)
  ) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_clear_go(i_clear_go), .i_clear_color(i_clear_color),
    .i_rast_valid(i_rast_valid), .o_rast_ready(o_rast_ready),
    .i_rast_vert_addr(i_rast_vert_addr), .i_rast_horiz_addr(i_rast_horiz_addr),
    .i_rast_data(i_rast_data), .o_fb_write_en(o_fb_write_en),
    .o_fb_vert_addr(o_fb_vert_addr), .o_fb_horiz_addr(o_fb_horiz_addr),
    .o_fb_data(o_fb_data), .o_clear_busy(o_clear_busy), .o_clear_done(o_clear_done)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic           valid;
    logic [VW-1:0]  v;
    logic [HW-1:0]  h;
    logic [FBW-1:0] d;
    logic           exp_we;
    logic [VW-1:0]  exp_v;
    logic [HW-1:0]  exp_h;
    logic [FBW-1:0] exp_d;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_rast(input logic valid, input logic [VW-1:0] v,
                            input logic [HW-1:0] h, input logic [FBW-1:0] d);
    i_rast_valid      = valid;
    i_rast_vert_addr  = v;
    i_rast_horiz_addr = h;
    i_rast_data       = d;
  endtask

  task automatic push_sweep(input logic [FBW-1:0] color);
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++)
        exp_q.push_back({VW'(v), HW'(h), color});
  endtask

  // Full clear sweep; optional second go mid-sweep and optional rasterizer held valid.
  task automatic sweep(input logic [FBW-1:0] color, input int busy_go_at, input bit hold);
    int done_cnt = 0, done_cyc = 0, busy_cyc = 0, rast_in = 0;
    int post_cnt = 0, post_cyc = 0, extra = 0;
    logic [W-1:0] got;
    logic [W-1:0] exp_w;
    drive_rast(1'b0, '0, '0, '0);
    i_clear_go = 1'b1;
    i_clear_color = color;
    step();
    i_clear_go = 1'b0;
    chk("busy_after_go", o_clear_busy, 1);
    if (o_clear_busy) busy_cyc++;
    push_sweep(color);
    if (hold) drive_rast(1'b1, 2'd1, 2'd2, 12'h5A5);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == busy_go_at) begin
        i_clear_go = 1'b1;
        i_clear_color = 12'hF00;
      end else begin
        i_clear_go = 1'b0;
      end
      if (done_cnt == 0)
        chk("ready_in_clear", o_rast_ready, RR && cyc >= 2 && (!hold || cyc % 2 == 0));
      step();
      if (o_clear_busy) busy_cyc++;
      if (o_clear_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_fb_write_en) begin
        got = {o_fb_vert_addr, o_fb_horiz_addr, o_fb_data};
        if (hold && got == {2'd1, 2'd2, 12'h5A5}) begin
          if (done_cnt == 0) rast_in++;
          else begin
            post_cnt++;
            post_cyc = cyc;
            i_rast_valid = 1'b0;
          end
        end else if (done_cnt > 0 && done_cyc != cyc) begin
          extra++;
        end else if (exp_q.size() == 0) begin
          chk("clear_write_unexpected", got, 0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("clear_write", got, exp_w);
        end
      end
    end
    i_clear_go = 1'b0;
    i_rast_valid = 1'b0;
    chk("clear_writes_left", exp_q.size(), 0);
    exp_q.delete();
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_cyc, (RR && hold) ? 23 : 12);
    chk("busy_cycles", busy_cyc, (RR && hold) ? 23 : 12);
    chk("rast_writes_in_sweep", rast_in, (RR && hold) ? 11 : 0);
    chk("rast_write_after_done", post_cnt, hold ? 1 : 0);
    chk("rast_after_done_cycle", post_cyc, hold ? done_cyc + 1 : 0);
    chk("writes_after_done", extra, 0);
  endtask

  initial begin
    int seen;
    vecs[0] = '{1'b1, 2'd2, 2'd3, 12'hABC, 1'b1, 2'd2, 2'd3, 12'hABC};
    vecs[1] = '{1'b0, 2'd1, 2'd1, 12'h111, 1'b0, 2'd2, 2'd3, 12'hABC};
    vecs[2] = '{1'b1, 2'd0, 2'd1, 12'h123, 1'b1, 2'd0, 2'd1, 12'h123};
    vecs[3] = '{1'b1, 2'd1, 2'd0, 12'hFFF, 1'b1, 2'd1, 2'd0, 12'hFFF};
    vecs[4] = '{1'b0, 2'd0, 2'd0, 12'h000, 1'b0, 2'd1, 2'd0, 12'hFFF};

    i_arst = 1'b1;
    i_clear_go = 1'b0;
    i_clear_color = '0;
    drive_rast(1'b0, '0, '0, '0);
    step();
    step();
    chk("rst_we", o_fb_write_en, 0);
    chk("rst_busy", o_clear_busy, 0);
    chk("rst_ready", o_rast_ready, 0);
    i_arst = 1'b0;
    #1;
    chk("post_rst_ready", o_rast_ready, 1);

    // IDLE rasterizer writes
    foreach (vecs[i]) begin
      drive_rast(vecs[i].valid, vecs[i].v, vecs[i].h, vecs[i].d);
      chk("idle_ready", o_rast_ready, 1);
      step();
      chk("vec_we", o_fb_write_en, vecs[i].exp_we);
      chk("vec_addr_data", {o_fb_vert_addr, o_fb_horiz_addr, o_fb_data},
          {vecs[i].exp_v, vecs[i].exp_h, vecs[i].exp_d});
    end
    drive_rast(1'b0, '0, '0, '0);

    sweep(12'h0F0, 0, 1'b0);
    sweep(12'h0F0, 5, 1'b0);
    sweep(12'h0F0, 0, 1'b1);

    // go together with a rasterizer transfer in IDLE
    i_clear_go = 1'b1;
    i_clear_color = 12'h0AA;
    drive_rast(1'b1, 2'd0, 2'd3, 12'h777);
    step();
    i_clear_go = 1'b0;
    drive_rast(1'b0, '0, '0, '0);
    chk("simul_rast_write", {o_fb_write_en, o_fb_vert_addr, o_fb_horiz_addr, o_fb_data},
        {1'b1, 2'd0, 2'd3, 12'h777});
    chk("simul_busy", o_clear_busy, 1);
    step();
    chk("simul_first_clear", {o_fb_write_en, o_fb_vert_addr, o_fb_horiz_addr, o_fb_data},
        {1'b1, 2'd0, 2'd0, 12'h0AA});
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      step();
      if (o_clear_done) seen = 1;
    end
    chk("simul_done_seen", seen, 1);
    step();

    // go in the done cycle restarts
    i_clear_go = 1'b1;
    i_clear_color = 12'h0F0;
    step();
    i_clear_go = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("restart_done", o_clear_done, 1);
    i_clear_go = 1'b1;
    i_clear_color = 12'h00F;
    step();
    i_clear_go = 1'b0;
    chk("restart_busy", o_clear_busy, 1);
    step();
    chk("restart_first", {o_fb_write_en, o_fb_vert_addr, o_fb_horiz_addr, o_fb_data},
        {1'b1, 2'd0, 2'd0, 12'h00F});
    for (int c = 0; c < 11; c++) step();
    chk("restart_last", {o_clear_done, o_fb_vert_addr, o_fb_horiz_addr, o_fb_data},
        {1'b1, 2'd2, 2'd3, 12'h00F});
    step();

    // reset mid-sweep
    i_clear_go = 1'b1;
    i_clear_color = 12'h0F0;
    step();
    i_clear_go = 1'b0;
    for (int c = 0; c < 5; c++) step();
    i_arst = 1'b1;
    #1;
    chk("abort_outputs", {o_fb_write_en, o_fb_vert_addr, o_fb_horiz_addr, o_fb_data,
                          o_clear_busy, o_clear_done, o_rast_ready}, 0);
    step();
    i_arst = 1'b0;
    #1;
    chk("abort_ready", o_rast_ready, 1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (o_clear_done || o_fb_write_en || o_clear_busy) seen++;
    end
    chk("abort_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
